// File: rtl/chunked_adder.sv
// Multi-cycle ripple adder: adds two WIDTH-bit operands CHUNK bits per clock with a registered inter-chunk carry.
// Optional subtract mode is enabled by defining CHUNKED_ADDER_SUBTRACT_EN (adds the 'sub' input).
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
`ifdef CHUNKED_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carryout_reg;
  logic             overflow_reg;

  logic [WIDTH-1:0] b_next;
  logic             carry_next;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic [CHUNK:0]   chunk_total;
  logic             chunk_cout;
  logic             msb_cin;
  int               base;

  // Subtraction is folded into the operand capture: a - b = a + ~b + 1.
  always_comb begin
    b_next     = b;
    carry_next = carryin;
`ifdef CHUNKED_ADDER_SUBTRACT_EN
    if (sub) begin
      b_next     = ~b;
      carry_next = 1'b1;
    end
`endif
  end

  always_comb begin
    base        = int'(cnt_reg) * CHUNK;
    chunk_a     = a_reg[base +: CHUNK];
    chunk_b     = b_reg[base +: CHUNK];
    chunk_total = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_reg};
    chunk_s     = chunk_total[CHUNK-1:0];
    chunk_cout  = chunk_total[CHUNK];
    // Carry into the chunk MSB recovered from the MSB sum bit, so CHUNK=1 needs no special case.
    msb_cin     = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_s[CHUNK-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      carry_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      carryout_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b_next;
            carry_reg <= carry_next;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum_reg[base +: CHUNK] <= chunk_s;
          carry_reg              <= chunk_cout;
          if (cnt_reg == LAST) begin
            carryout_reg <= chunk_cout;
            overflow_reg <= chunk_cout ^ msb_cin;
            state_reg    <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign carryout  = carryout_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: a CHUNK=8 instance and a CHUNK=32 instance run side by side on shared stimulus.
module tb_chunked_adder;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        carryin;
  logic        sub;
  logic        out_ready;

  logic        in_ready0, out_valid0, carryout0, overflow0;
  logic [31:0] sum0;
  logic        in_ready1, out_valid1, carryout1, overflow1;
  logic [31:0] sum1;

  int checks;
  int errors;

  chunked_adder #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .carryin(carryin),
`ifdef CHUNKED_ADDER_SUBTRACT_EN
    .sub(sub),
`endif
    .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0),
    .carryout(carryout0), .overflow(overflow0)
  );

  chunked_adder #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .carryin(carryin),
`ifdef CHUNKED_ADDER_SUBTRACT_EN
    .sub(sub),
`endif
    .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1),
    .carryout(carryout1), .overflow(overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on both instances; optionally holds out_ready low for 'hold' cycles with in_valid pulses.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic cin, input logic sb,
                       input logic [31:0] es, input logic eco, input logic eov,
                       input int hold, input string tag);
    int lat;
    int lat1;
    check({tag, ".in_ready_pre"}, {63'd0, in_ready0}, 64'd1);
    a        = av;
    b        = bv;
    carryin  = cin;
    sub      = sb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".in_ready_busy"}, {63'd0, in_ready0}, 64'd0);
    lat  = 0;
    lat1 = -1;
    while (!out_valid0 && lat < 20) begin
      if (out_valid1 && lat1 < 0) lat1 = lat;
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid1 && lat1 < 0) lat1 = lat;
    check({tag, ".lat8"}, 64'(lat), 64'd4);
    check({tag, ".lat32"}, 64'(lat1), 64'd1);
    check({tag, ".sum8"}, {32'd0, sum0}, {32'd0, es});
    check({tag, ".flags8"}, {62'd0, carryout0, overflow0}, {62'd0, eco, eov});
    check({tag, ".sum32"}, {32'd0, sum1}, {32'd0, es});
    check({tag, ".flags32"}, {62'd0, carryout1, overflow1}, {62'd0, eco, eov});
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a        = $urandom;
      b        = $urandom;
      @(posedge clk); #1;
      check({tag, ".hold_state"}, {60'd0, in_ready0, out_valid0, in_ready1, out_valid1}, 64'h5);
      check({tag, ".hold_out8"}, {30'd0, carryout0, overflow0, sum0}, {30'd0, eco, eov, es});
      check({tag, ".hold_out32"}, {30'd0, carryout1, overflow1, sum1}, {30'd0, eco, eov, es});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".release"}, {60'd0, in_ready0, out_valid0, in_ready1, out_valid1}, 64'hA);
    $display("op %s a=%08h b=%08h cin=%0b sub=%0b -> sum=%08h co=%0b ov=%0b lat=%0d",
             tag, av, bv, cin, sb, sum0, carryout0, overflow0, lat);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    carryin   = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.state", {60'd0, in_ready0, out_valid0, in_ready1, out_valid1}, 64'hA);
    check("reset.out8", {30'd0, carryout0, overflow0, sum0}, 64'd0);
    check("reset.out32", {30'd0, carryout1, overflow1, sum1}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, "max_plus_one");
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, "pos_overflow");
    do_op(32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 10, "carryin_backpressure");
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0, "neg_overflow");

    // Reset two cycles into RUN; the previous nonzero result must not survive.
    a        = 32'h1234_5678;
    b        = 32'h1111_1111;
    carryin  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset.state", {60'd0, in_ready0, out_valid0, in_ready1, out_valid1}, 64'hA);
    check("midreset.out8", {30'd0, carryout0, overflow0, sum0}, 64'd0);
    check("midreset.out32", {30'd0, carryout1, overflow1, sum1}, 64'd0);
    $display("op midreset sum=%08h co=%0b ov=%0b", sum0, carryout0, overflow0);
    #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 0, "after_reset");

`ifdef CHUNKED_ADDER_SUBTRACT_EN
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, "sub_5_7");
    do_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 0, "sub_7_5");
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, "sub_min_1");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
